approx_mac_accumulator: RTL and testbench
=========================================

# approx_mac_accumulator

Downstream consumer of the 8x8 approximate multiplier's 16-bit product. It accepts a stream of products over a valid/ready handshake and sums each frame, delimited by `in_last`, into a saturating accumulator. The finished sum is held in a one-entry output register until the downstream stage takes it. The block turns the purely combinational multiplier into a dot-product / MAC datapath stage.

## Interface
- `ACC_W`, 24: accumulator and result width; legal range 17..32.
- `MAX_LEN`, 256: maximum terms per frame; the frame is force-closed when this count is reached.
- `CNT_W`, 9: term-counter width; must satisfy 2^CNT_W > MAX_LEN.
- `CLK`, in, 1: single clock; all state updates on the rising edge.
- `RST_N`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: `in_prod` and `in_last` are valid.
- `in_ready`, out, 1: block can accept a term this cycle.
- `in_prod`, in, 16: unsigned product term.
- `in_last`, in, 1: this term closes the frame.
- `out_valid`, out, 1: result register holds an unconsumed frame sum.
- `out_ready`, in, 1: downstream accepts the result.
- `out_acc`, out, ACC_W: frame sum, saturated.
- `out_count`, out, CNT_W: number of terms in the frame.
- `out_sat`, out, 1: saturation occurred at least once in the frame.
- `out_trunc`, out, 1: frame closed by `MAX_LEN` rather than by `in_last`.

## Operation
- Accept = `in_valid & in_ready`. Result transfer = `out_valid & out_ready`.
- **States:**
  - IDLE: no frame open.
  - ACCUM: frame open.
  - HOLD: result valid, waiting for downstream.
- **`in_ready`** = (state != HOLD) | `out_ready`. It is combinational from state and `out_ready` only, never from `in_valid`.
- **Accept in IDLE:** acc <= zero-extended `in_prod`, cnt <= 1, sat <= 0.
- **Accept in ACCUM:** acc <= sat_add(acc, `in_prod`), cnt <= cnt+1, sat <= sat | overflow.
- **Frame close:** the accepted term has `in_last`=1, or the new cnt equals `MAX_LEN`. On close:
  - load `out_acc`, `out_count`, `out_sat` from the post-update values;
  - set `out_trunc` = (`MAX_LEN` reached) & ~`in_last`;
  - go to HOLD.
- **No accept in IDLE/ACCUM:** state and acc are unchanged; no bubbles are inserted.
- **HOLD with transfer and no accept:** go to IDLE.
- **HOLD with transfer and simultaneous accept:** the accepted term starts a new frame exactly as in IDLE. The next state is ACCUM, or HOLD if the term closes the frame; in that case the output registers reload in the same cycle.
- **HOLD without transfer:** all output registers stay stable.
- **Saturation:** the unsigned sum is computed ACC_W+1 bits wide. If bit ACC_W is set, the result clamps to all-ones (2^ACC_W−1) and overflow=1. Once clamped, the accumulator stays at all-ones for the rest of the frame.
- **Single-term frame** (IDLE accept with `in_last`=1): result = `in_prod`, count = 1.

## Timing
- **Reset** (async assert, sync-safe deassert handled upstream): state=IDLE, acc=0, cnt=0.
  - Outputs during reset: `out_valid`=0, `out_acc`=0, `out_count`=0, `out_sat`=0, `out_trunc`=0, `in_ready`=1.
- **Reset mid-frame** discards the partial sum and any held result; no output is produced for that frame.
- **Latency:** closing term accepted at edge k → `out_valid`=1 from edge k through to the transfer edge. This is one cycle of latency.
- **Throughput:** one term per cycle sustained, including across frame boundaries while downstream holds `out_ready`=1.
- `out_*` are register outputs with no combinational path from inputs.

## Structure
- Package `approx_mac_pkg` contains:
  - state enum `mac_state_t` {IDLE, ACCUM, HOLD};
  - localparam `PROD_W`=16;
  - the `ACC_W` legality check.
- One sub-module, `sat_add`: parameterised ACC_W, combinational. It takes acc and a 16-bit zero-extended operand and returns the clamped sum plus an overflow flag.
- The FSM, counter and output register live in the top module.

## Test plan
- **Basic frame:** reset, then terms 0x0008, 0x0010, 0x0100 (last) back-to-back → one cycle after the last accept: `out_acc`=0x000118, `out_count`=3, `out_sat`=0, `out_trunc`=0.
- **Back-pressure:** frame {0x1000 last} with `out_ready`=0 for 5 cycles → `out_valid` held and `in_ready`=0 throughout. Set `out_ready`=1 together with `in_valid` carrying {0x0020 last} → both transfers occur on the same edge, and the next `out_acc`=0x000020.
- **Saturation** (ACC_W=17): three terms of 0xFFFF, the last flagged `in_last` → `out_acc`=0x1FFFF, `out_count`=3, `out_sat`=1.
- **Truncation** (MAX_LEN=4): six terms of 0x0001, none flagged `in_last` →
  - first result: `out_acc`=4, `out_count`=4, `out_trunc`=1;
  - second frame remains open with acc=2 and `out_valid`=0.
- **Reset mid-frame:** two terms of 0x0050 accepted, then assert `RST_N`=0 for 1 cycle → all outputs return to zero and `in_ready`=1. A subsequent {0x0003 last} yields `out_acc`=3, `out_count`=1.
- **Gaps:** `in_valid` toggling 1,0,0,1,0,1(last) with terms 1, 2, 3 → `out_acc`=6, `out_count`=3, and the sum is unaffected by idle cycles.

Source files
------------

// File: rtl/approx_mac_pkg.sv
// Shared types and constants for the approximate-multiplier MAC accumulator.
package approx_mac_pkg;

    // Frame-tracking state of the accumulator.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } mac_state_t;

    // Width of the product term coming from the 8x8 multiplier.
    localparam int PROD_W    = 16;

    // Accumulator must be wider than one product and fit in 32 bits.
    localparam int ACC_W_MIN = 17;
    localparam int ACC_W_MAX = 32;

    function automatic bit acc_w_legal(input int w);
        return (w >= ACC_W_MIN) && (w <= ACC_W_MAX);
    endfunction

endpackage

// File: rtl/approx_mac_accumulator_sat_add.sv
// Unsigned saturating adder: acc + zero-extended 16-bit product, clamped to all-ones.
module sat_add
    import approx_mac_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [PROD_W-1:0] op_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              ovf_o
);

    logic [ACC_W:0] wide_sum;

    // One extra bit catches the carry-out; any carry means clamp.
    always_comb begin
        wide_sum = {1'b0, acc_i} + {{(ACC_W + 1 - PROD_W){1'b0}}, op_i};
        ovf_o    = wide_sum[ACC_W];
        sum_o    = ovf_o ? {ACC_W{1'b1}} : wide_sum[ACC_W-1:0];
    end

endmodule

// File: rtl/approx_mac_accumulator.sv
// Frame-based saturating accumulator for the approximate multiplier's products.
//
//   state | meaning
//   ------+-------------------------------------------
//   IDLE  | no frame open
//   ACCUM | frame open, partial sum in acc_q
//   HOLD  | result registered, waiting for downstream
module approx_mac_accumulator
    import approx_mac_pkg::*;
#(
    parameter int ACC_W   = 24,
    parameter int MAX_LEN = 256,
    parameter int CNT_W   = 9
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_sat,
    output logic              out_trunc
);

    if (!acc_w_legal(ACC_W)) begin : g_bad_acc_w
        $error("approx_mac_accumulator: ACC_W must be within 17..32");
    end
    if ((64'd1 << CNT_W) <= 64'(MAX_LEN)) begin : g_bad_cnt_w
        $error("approx_mac_accumulator: CNT_W too narrow for MAX_LEN");
    end

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

    mac_state_t       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;

    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_acc_q, out_acc_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_sat_q, out_sat_d;
    logic             out_trunc_q, out_trunc_d;

    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic             accept;
    logic             start_new;
    logic             max_hit;
    logic             close;
    logic [ACC_W-1:0] new_acc;
    logic [CNT_W-1:0] new_cnt;
    logic             new_sat;

    sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .acc_i (acc_q),
        .op_i  (in_prod),
        .sum_o (add_sum),
        .ovf_o (add_ovf)
    );

    // Ready depends only on state and downstream ready so that no loop forms through in_valid.
    always_comb begin
        in_ready = (state_q != HOLD) | out_ready;
    end

    // Post-update frame values for the term being accepted this cycle.
    always_comb begin
        accept    = in_valid & in_ready;
        // In HOLD an accept implies a transfer, so the term opens a fresh frame as in IDLE.
        start_new = (state_q != ACCUM);
        new_acc   = start_new ? {{(ACC_W - PROD_W){1'b0}}, in_prod} : add_sum;
        new_cnt   = start_new ? CNT_W'(1) : cnt_q + CNT_W'(1);
        new_sat   = start_new ? 1'b0 : (sat_q | add_ovf);
        max_hit   = (new_cnt == MAX_CNT);
        close     = accept & (in_last | max_hit);
    end

    // Next-state, frame accumulator and output register load.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q & ~out_ready;
        out_acc_d   = out_acc_q;
        out_count_d = out_count_q;
        out_sat_d   = out_sat_q;
        out_trunc_d = out_trunc_q;

        if (accept) begin
            acc_d = new_acc;
            cnt_d = new_cnt;
            sat_d = new_sat;
        end

        if (close) begin
            out_valid_d = 1'b1;
            out_acc_d   = new_acc;
            out_count_d = new_cnt;
            out_sat_d   = new_sat;
            out_trunc_d = max_hit & ~in_last;
        end

        case (state_q)
            IDLE: begin
                if (accept) state_d = close ? HOLD : ACCUM;
            end
            ACCUM: begin
                if (close) state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    if (accept) state_d = close ? HOLD : ACCUM;
                    else        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any partial frame and held result.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_count_q <= '0;
            out_sat_q   <= 1'b0;
            out_trunc_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_count_q <= out_count_d;
            out_sat_q   <= out_sat_d;
            out_trunc_q <= out_trunc_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        out_valid = out_valid_q;
        out_acc   = out_acc_q;
        out_count = out_count_q;
        out_sat   = out_sat_q;
        out_trunc = out_trunc_q;
    end

endmodule

// File: tb/tb_approx_mac_accumulator.sv
// Directed and randomized checks of the MAC accumulator against a frame-level model.
module tb_approx_mac_accumulator;

    localparam int ACC_W   = 17;
    localparam int MAX_LEN = 4;
    localparam int CNT_W   = 3;
    localparam longint ACC_MAX = (64'd1 << ACC_W) - 1;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_prod;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [CNT_W-1:0] out_count;
    logic             out_sat;
    logic             out_trunc;

    int checks   = 0;
    int failures = 0;

    approx_mac_accumulator #(
        .ACC_W   (ACC_W),
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_count (out_count),
        .out_sat   (out_sat),
        .out_trunc (out_trunc)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] p, input logic l);
        in_valid = v;
        in_prod  = p;
        in_last  = l;
    endtask

    task automatic check_result(input string tag, input logic [31:0] acc, input logic [31:0] cnt,
                                input logic sat, input logic trunc);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_acc"},   32'(out_acc),   acc);
        check({tag, "_count"}, 32'(out_count), cnt);
        check({tag, "_sat"},   32'(out_sat),   32'(sat));
        check({tag, "_trunc"}, 32'(out_trunc), 32'(trunc));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_acc"},   32'(out_acc),   32'd0);
        check({tag, "_count"}, 32'(out_count), 32'd0);
        check({tag, "_sat"},   32'(out_sat),   32'd0);
        check({tag, "_trunc"}, 32'(out_trunc), 32'd0);
        check({tag, "_ready"}, 32'(in_ready),  32'd1);
    endtask

    // Frame-level reference model state for the randomized phase.
    bit      m_pending;
    bit      m_open;
    longint  m_sum;
    int      m_cnt;
    bit      m_sat;
    longint  h_acc;
    int      h_cnt;
    bit      h_sat;
    bit      h_trunc;

    initial begin
        drive(1'b0, 16'h0, 1'b0);
        out_ready = 1'b1;
        RST_N     = 1'b0;
        #2;
        check_zero("reset");
        step();
        step();
        RST_N = 1'b1;
        step();

        // Basic frame
        drive(1'b1, 16'h0008, 1'b0); step();
        drive(1'b1, 16'h0010, 1'b0); step();
        drive(1'b1, 16'h0100, 1'b1); step();
        drive(1'b0, 16'h0, 1'b0);
        check_result("basic", 32'h118, 32'd3, 1'b0, 1'b0);
        step();
        check("basic_drain", 32'(out_valid), 32'd0);

        // Back-pressure with simultaneous transfer and accept
        out_ready = 1'b0;
        drive(1'b1, 16'h1000, 1'b1); step();
        drive(1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_valid",    32'(out_valid), 32'd1);
            check("bp_acc",      32'(out_acc),   32'h1000);
            step();
        end
        out_ready = 1'b1;
        drive(1'b1, 16'h0020, 1'b1);
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        step();
        drive(1'b0, 16'h0, 1'b0);
        check_result("bp_next", 32'h20, 32'd1, 1'b0, 1'b0);
        step();

        // Saturation
        drive(1'b1, 16'hFFFF, 1'b0); step();
        drive(1'b1, 16'hFFFF, 1'b0); step();
        drive(1'b1, 16'hFFFF, 1'b1); step();
        drive(1'b0, 16'h0, 1'b0);
        check_result("sat", 32'h1FFFF, 32'd3, 1'b1, 1'b0);
        step();

        // Truncation at MAX_LEN, then the follow-on frame keeps running
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 16'h0001, 1'b0);
            step();
            if (i == 3) check_result("trunc", 32'd4, 32'd4, 1'b0, 1'b1);
            if (i >= 4) check("trunc_open_valid", 32'(out_valid), 32'd0);
        end
        drive(1'b1, 16'h0000, 1'b1); step();
        drive(1'b0, 16'h0, 1'b0);
        check_result("trunc_tail", 32'd2, 32'd3, 1'b0, 1'b0);
        step();

        // Reset mid-frame
        drive(1'b1, 16'h0050, 1'b0); step();
        drive(1'b1, 16'h0050, 1'b0); step();
        drive(1'b0, 16'h0, 1'b0);
        RST_N = 1'b0;
        #2;
        check_zero("midrst");
        step();
        RST_N = 1'b1;
        drive(1'b1, 16'h0003, 1'b1); step();
        drive(1'b0, 16'h0, 1'b0);
        check_result("midrst_after", 32'd3, 32'd1, 1'b0, 1'b0);
        step();

        // Gaps between terms
        drive(1'b1, 16'd1, 1'b0); step();
        drive(1'b0, 16'd0, 1'b0); step();
        step();
        drive(1'b1, 16'd2, 1'b0); step();
        drive(1'b0, 16'd0, 1'b0); step();
        drive(1'b1, 16'd3, 1'b1); step();
        drive(1'b0, 16'd0, 1'b0);
        check_result("gaps", 32'd6, 32'd3, 1'b0, 1'b0);
        step();

        // Randomized traffic against the frame-level model
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        m_pending = 1'b0;
        m_open    = 1'b0;
        m_sum     = 0;
        m_cnt     = 0;
        m_sat     = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            bit     v, l, r, acc_ok;
            logic [15:0] p;
            v = ($urandom_range(0, 9) < 7);
            l = ($urandom_range(0, 9) < 2);
            r = ($urandom_range(0, 9) < 6);
            p = ($urandom_range(0, 2) == 0) ? 16'hF000 + 16'($urandom_range(0, 16'h0FFF))
                                            : 16'($urandom);
            drive(v, p, l);
            out_ready = r;
            #1;
            check("rnd_in_ready", 32'(in_ready), 32'(!m_pending || r));
            check("rnd_valid",    32'(out_valid), 32'(m_pending));
            if (m_pending) begin
                check("rnd_acc",   32'(out_acc),   32'(h_acc));
                check("rnd_count", 32'(out_count), 32'(h_cnt));
                check("rnd_sat",   32'(out_sat),   32'(h_sat));
                check("rnd_trunc", 32'(out_trunc), 32'(h_trunc));
            end
            acc_ok = v && (!m_pending || r);
            if (m_pending && r) m_pending = 1'b0;
            if (acc_ok) begin
                if (!m_open) begin
                    m_open = 1'b1;
                    m_sum  = 0;
                    m_cnt  = 0;
                    m_sat  = 1'b0;
                end
                m_sum = m_sum + longint'(p);
                if (m_sum > ACC_MAX) begin
                    m_sum = ACC_MAX;
                    m_sat = 1'b1;
                end
                m_cnt++;
                if (l || m_cnt == MAX_LEN) begin
                    h_acc     = m_sum;
                    h_cnt     = m_cnt;
                    h_sat     = m_sat;
                    h_trunc   = !l && (m_cnt == MAX_LEN);
                    m_pending = 1'b1;
                    m_open    = 1'b0;
                end
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
